predicate_writeback_queue: RTL and testbench
============================================

Name: predicate_writeback_queue

Overview:
- Upstream feeder of predicate_register_block. Accepts per-lane compare results (warp, predicate address, lane mask, 8 predicate bits) from the ALU writeback bus via valid/ready.
- Buffers results in a small FIFO and drives the register block's write port (write_en, waddr, wdata_0..7, warp_selector) with at most one write per cycle.
- Provides a pending-write hazard lookup so issue logic can stall reads of predicates still in flight.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- NUM_LANES, 8, lanes; width of lane mask and predicate vector.
- WARP_W, 4, warp id width (16 warps).
- ADDR_W, 6, predicate register address width (64 registers).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  writeback result valid.
- in_ready  output  1  queue can accept.
- in_warp  input  WARP_W  destination warp.
- in_addr  input  ADDR_W  destination predicate register.
- in_lane_mask  input  NUM_LANES  lanes to write.
- in_pred  input  NUM_LANES  predicate value per lane; bit i goes to wdata_i.
- pr_wr_stall  input  1  register block's warp_selector is reserved for reads this cycle; do not issue a write.
- pr_write_en  output  NUM_LANES  per-lane write enable to the register block.
- pr_waddr  output  ADDR_W  write address.
- pr_wdata  output  NUM_LANES  write data; bit i goes to wdata_i.
- pr_warp_selector  output  WARP_W  warp for the write.
- q_warp  input  WARP_W  hazard query warp.
- q_addr  input  ADDR_W  hazard query address.
- q_hit  output  1  a write to (q_warp, q_addr) is pending.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n low): FIFO empty, read/write pointers 0, count=0, pr_write_en=0, pr_waddr=0, pr_wdata=0, pr_warp_selector=0. in_ready is 1 and q_hit is 0 once rst_n is released.
- Reset mid-operation discards all queued entries; no partial writes are issued.
- in_ready = (count < DEPTH), combinational from registered count. A pop in the same cycle does not raise in_ready.
- Push: on posedge with in_valid & in_ready & (in_lane_mask != 0), the entry is written at the tail.
- An entry with in_lane_mask == 0 is accepted (handshake completes) and dropped, not enqueued.
- in_valid while !in_ready: no state change; the upstream holds the request.
- Pop/issue: on posedge, if count>0 and !pr_wr_stall, the head is loaded into the output registers. pr_write_en = lane_mask, and waddr/wdata/warp take the entry fields.
- Otherwise pr_write_en loads 0, and pr_waddr/pr_wdata/pr_warp_selector hold their values.
- pr_write_en is therefore a one-cycle pulse per entry. Back-to-back entries issue on consecutive cycles.
- Latency: push at edge N produces outputs valid after edge N+1, and the register block commits at edge N+2.
- Simultaneous push and pop: both occur; count is unchanged.
- Pop with count==0: nothing happens.
- Pointers wrap modulo DEPTH.
- Ordering: strict FIFO. Two entries to the same (warp, addr) are issued in arrival order, and the later one wins in the register block.
- q_hit (combinational): 1 if any valid FIFO entry matches (q_warp, q_addr) with a nonzero mask, or if pr_write_en != 0 and the output registers match. A same-cycle in_valid does not set q_hit.

Optional Feature:
- Macro PRED_WB_BYPASS_EN.
- Defined: when count==0, !pr_wr_stall and an accepted in_valid has a nonzero mask, the input loads directly into the output registers at the same edge; the FIFO is not written. Latency becomes 1 edge.
- Defined, push with count>0: behaves as without the macro.
- Not defined: all entries pass through the FIFO, with the 2-edge minimum latency above.

Test Plan:
- Reset, then push warp 3, addr 0x2A, mask 0xFF, pred 0xA5 -> after edge N+1: pr_write_en=0xFF, pr_waddr=0x2A, pr_wdata=0xA5, pr_warp_selector=3 for exactly one cycle. Reading the register block then returns rdata_*_i = bit i of 0xA5.
- Hold pr_wr_stall=1 and push DEPTH=4 entries -> count=4, in_ready=0. A 5th in_valid is not accepted. Release stall -> 4 writes issue on consecutive cycles in order, then count=0.
- Push mask=0x00 -> handshake completes, count stays 0, pr_write_en never pulses.
- With an entry (warp 15, addr 0x3F) queued under stall: q_warp=15, q_addr=0x3F gives q_hit=1; q_addr=0x3E gives q_hit=0. After the write pulse, q_hit=0.
- Assert rst_n=0 mid-cycle with count=3 -> outputs are immediately 0, count=0, and no writes issue after release.
- With PRED_WB_BYPASS_EN defined, count=0: push at edge N -> pr_write_en nonzero after edge N. Without the macro -> after edge N+1.

Source files
------------

// File: rtl/predicate_writeback_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : predicate_writeback_queue_if
// Description : Writeback-in, register-write-out and hazard-query bundle for
//               predicate_writeback_queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface predicate_writeback_queue_if #(
    parameter int DEPTH     = 4,
    parameter int NUM_LANES = 8,
    parameter int WARP_W    = 4,
    parameter int ADDR_W    = 6
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [WARP_W-1:0]    in_warp;
    logic [ADDR_W-1:0]    in_addr;
    logic [NUM_LANES-1:0] in_lane_mask;
    logic [NUM_LANES-1:0] in_pred;
    logic                 pr_wr_stall;
    logic [NUM_LANES-1:0] pr_write_en;
    logic [ADDR_W-1:0]    pr_waddr;
    logic [NUM_LANES-1:0] pr_wdata;
    logic [WARP_W-1:0]    pr_warp_selector;
    logic [WARP_W-1:0]    q_warp;
    logic [ADDR_W-1:0]    q_addr;
    logic                 q_hit;
    logic [c_cnt_w-1:0]   count;

    modport slave (
        input  in_valid, in_warp, in_addr, in_lane_mask, in_pred,
        input  pr_wr_stall, q_warp, q_addr,
        output in_ready, pr_write_en, pr_waddr, pr_wdata, pr_warp_selector,
        output q_hit, count
    );

    modport master (
        output in_valid, in_warp, in_addr, in_lane_mask, in_pred,
        output pr_wr_stall, q_warp, q_addr,
        input  in_ready, pr_write_en, pr_waddr, pr_wdata, pr_warp_selector,
        input  q_hit, count
    );
endinterface
`default_nettype wire

// File: rtl/predicate_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : predicate_writeback_queue
// Description : FIFO between the ALU writeback bus and the predicate register
//               block write port, with a pending-write hazard lookup.
//               Optional macro PRED_WB_BYPASS_EN: empty-queue results skip the
//               FIFO and reach the write port one edge earlier.
// Revision    : 1.0 - initial release
// ============================================================================
module predicate_writeback_queue #(
    parameter int DEPTH     = 4,
    parameter int NUM_LANES = 8,
    parameter int WARP_W    = 4,
    parameter int ADDR_W    = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    predicate_writeback_queue_if.slave  bus
);
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_ent_w  = WARP_W + ADDR_W + 2 * NUM_LANES;
    // Entry layout, MSB first: {warp, addr, lane_mask, pred}
    localparam int c_pred_lo = 0;
    localparam int c_mask_lo = NUM_LANES;
    localparam int c_addr_lo = 2 * NUM_LANES;
    localparam int c_warp_lo = 2 * NUM_LANES + ADDR_W;

    logic [c_ent_w-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic [NUM_LANES-1:0] r_write_en;
    logic [ADDR_W-1:0]    r_waddr;
    logic [NUM_LANES-1:0] r_wdata;
    logic [WARP_W-1:0]    r_warp_sel;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_nonzero;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_bypass;
    logic [c_ent_w-1:0]   w_head;
    logic [c_ent_w-1:0]   w_in_entry;
    logic [DEPTH-1:0]     w_entry_hit;
    logic                 w_out_hit;

    assign w_ready    = (r_count < c_cnt_w'(DEPTH));
    assign w_accept   = bus.in_valid & w_ready;
    assign w_nonzero  = |bus.in_lane_mask;
    assign w_pop      = (r_count != '0) & ~bus.pr_wr_stall;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_in_entry = {bus.in_warp, bus.in_addr, bus.in_lane_mask, bus.in_pred};

`ifdef PRED_WB_BYPASS_EN
    assign w_bypass = (r_count == '0) & ~bus.pr_wr_stall & w_accept & w_nonzero;
`else
    assign w_bypass = 1'b0;
`endif

    // Zero-mask results complete the handshake but never occupy a slot
    assign w_push = w_accept & w_nonzero & ~w_bypass;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write port: enables pulse for one cycle, address/data/warp hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_en <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_warp_sel <= '0;
        end else if (w_pop) begin
            r_write_en <= w_head[c_mask_lo +: NUM_LANES];
            r_waddr    <= w_head[c_addr_lo +: ADDR_W];
            r_wdata    <= w_head[c_pred_lo +: NUM_LANES];
            r_warp_sel <= w_head[c_warp_lo +: WARP_W];
        end else if (w_bypass) begin
            r_write_en <= bus.in_lane_mask;
            r_waddr    <= bus.in_addr;
            r_wdata    <= bus.in_pred;
            r_warp_sel <= bus.in_warp;
        end else begin
            r_write_en <= '0;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        logic [c_ptr_w-1:0] w_off;
        assign w_off = c_ptr_w'(gi) - r_rd_ptr;
        assign w_entry_hit[gi] = ({1'b0, w_off} < r_count)
                               && (r_mem[gi][c_warp_lo +: WARP_W] == bus.q_warp)
                               && (r_mem[gi][c_addr_lo +: ADDR_W] == bus.q_addr)
                               && (|r_mem[gi][c_mask_lo +: NUM_LANES]);
    end

    assign w_out_hit = (|r_write_en) && (r_warp_sel == bus.q_warp) && (r_waddr == bus.q_addr);

    assign bus.in_ready         = w_ready;
    assign bus.count            = r_count;
    assign bus.pr_write_en      = r_write_en;
    assign bus.pr_waddr         = r_waddr;
    assign bus.pr_wdata         = r_wdata;
    assign bus.pr_warp_selector = r_warp_sel;
    assign bus.q_hit            = (|w_entry_hit) | w_out_hit;

endmodule
`default_nettype wire

// File: tb/tb_predicate_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_predicate_writeback_queue
// Description : Directed and random stimulus against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_predicate_writeback_queue;
    localparam int DEPTH     = 4;
    localparam int NUM_LANES = 8;
    localparam int WARP_W    = 4;
    localparam int ADDR_W    = 6;

    typedef struct packed {
        logic [WARP_W-1:0]    warp;
        logic [ADDR_W-1:0]    addr;
        logic [NUM_LANES-1:0] mask;
        logic [NUM_LANES-1:0] pred;
    } entry_t;

    logic clk;
    logic rst_n;

    predicate_writeback_queue_if #(
        .DEPTH(DEPTH), .NUM_LANES(NUM_LANES), .WARP_W(WARP_W), .ADDR_W(ADDR_W)
    ) bus ();

    predicate_writeback_queue #(
        .DEPTH(DEPTH), .NUM_LANES(NUM_LANES), .WARP_W(WARP_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    entry_t               q_model [$];
    logic [NUM_LANES-1:0] m_en;
    logic [ADDR_W-1:0]    m_addr;
    logic [NUM_LANES-1:0] m_data;
    logic [WARP_W-1:0]    m_warp;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_hit(input logic [WARP_W-1:0] w, input logic [ADDR_W-1:0] a);
        logic h;
        h = 1'b0;
        foreach (q_model[i]) begin
            if (q_model[i].warp == w && q_model[i].addr == a && q_model[i].mask != 0) h = 1'b1;
        end
        if (m_en != 0 && m_warp == w && m_addr == a) h = 1'b1;
        return h;
    endfunction

    task automatic model_reset();
        q_model.delete();
        m_en   = '0;
        m_addr = '0;
        m_data = '0;
        m_warp = '0;
    endtask

    task automatic check_outputs(input string where);
        check_value({where, ".write_en"}, 32'(bus.pr_write_en),      32'(m_en));
        check_value({where, ".waddr"},    32'(bus.pr_waddr),         32'(m_addr));
        check_value({where, ".wdata"},    32'(bus.pr_wdata),         32'(m_data));
        check_value({where, ".warp"},     32'(bus.pr_warp_selector), 32'(m_warp));
        check_value({where, ".count"},    32'(bus.count),            32'(q_model.size()));
    endtask

    // Called just after a falling edge; leaves the bench just after the next one.
    task automatic step(input logic v, input logic [WARP_W-1:0] w, input logic [ADDR_W-1:0] a,
                        input logic [NUM_LANES-1:0] m, input logic [NUM_LANES-1:0] p,
                        input logic stall, input logic [WARP_W-1:0] qw, input logic [ADDR_W-1:0] qa);
        entry_t e;
        int     sz;
        logic   accept;
        check_outputs("out");
        bus.in_valid     = v;
        bus.in_warp      = w;
        bus.in_addr      = a;
        bus.in_lane_mask = m;
        bus.in_pred      = p;
        bus.pr_wr_stall  = stall;
        bus.q_warp       = qw;
        bus.q_addr       = qa;
        #1;
        check_value("q_hit",    32'(bus.q_hit),    32'(model_hit(qw, qa)));
        check_value("in_ready", 32'(bus.in_ready), 32'(q_model.size() < DEPTH));

        sz     = q_model.size();
        accept = v && (sz < DEPTH);
        if (sz > 0 && !stall) begin
            e      = q_model.pop_front();
            m_en   = e.mask;
            m_addr = e.addr;
            m_data = e.pred;
            m_warp = e.warp;
        end else begin
            m_en = '0;
        end
`ifdef PRED_WB_BYPASS_EN
        if (sz == 0 && !stall && accept && m != 0) begin
            m_en   = m;
            m_addr = a;
            m_data = p;
            m_warp = w;
        end else if (accept && m != 0) begin
            q_model.push_back('{warp: w, addr: a, mask: m, pred: p});
        end
`else
        if (accept && m != 0) q_model.push_back('{warp: w, addr: a, mask: m, pred: p});
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic random_step();
        logic [WARP_W-1:0]    w, qw;
        logic [ADDR_W-1:0]    a, qa;
        logic [NUM_LANES-1:0] m;
        entry_t               pick;
        w  = WARP_W'($urandom);
        a  = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
        m  = ($urandom_range(0, 7) == 0) ? '0 : NUM_LANES'($urandom);
        qw = WARP_W'($urandom);
        qa = ADDR_W'($urandom);
        if (q_model.size() > 0 && $urandom_range(0, 1) == 1) begin
            pick = q_model[$urandom_range(0, q_model.size() - 1)];
            qw   = pick.warp;
            qa   = pick.addr;
        end else if (m_en != 0 && $urandom_range(0, 2) == 0) begin
            qw = m_warp;
            qa = m_addr;
        end
        step(($urandom_range(0, 2) != 0), w, a, m, NUM_LANES'($urandom),
             ($urandom_range(0, 2) == 0), qw, qa);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_warp      = '0;
        bus.in_addr      = '0;
        bus.in_lane_mask = '0;
        bus.in_pred      = '0;
        bus.pr_wr_stall  = 1'b0;
        bus.q_warp       = '0;
        bus.q_addr       = '0;
        model_reset();

        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_value("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check_value("reset.q_hit",    32'(bus.q_hit),    32'd0);

        // Single write; latency depends on the bypass build
        step(1'b1, 4'd3, 6'h2A, 8'hFF, 8'hA5, 1'b0, 4'd3, 6'h2A);
        idle(3);

        // Fill under stall, fifth request refused, then drain in order
        for (int k = 0; k < DEPTH + 1; k++)
            step(1'b1, WARP_W'(k), ADDR_W'(k + 8), 8'h01 << k, NUM_LANES'(k * 37), 1'b1, '0, '0);
        idle(DEPTH + 2);

        // Zero mask is accepted and dropped
        step(1'b1, 4'd5, 6'h11, 8'h00, 8'hFF, 1'b0, 4'd5, 6'h11);
        idle(3);

        // Hazard lookup on a queued entry, during its pulse, and after it
        step(1'b1, 4'd15, 6'h3F, 8'h0F, 8'h05, 1'b1, 4'd15, 6'h3F);
        step(1'b0, '0, '0, '0, '0, 1'b1, 4'd15, 6'h3F);
        step(1'b0, '0, '0, '0, '0, 1'b1, 4'd15, 6'h3E);
        step(1'b0, '0, '0, '0, '0, 1'b0, 4'd15, 6'h3F);
        step(1'b0, '0, '0, '0, '0, 1'b0, 4'd15, 6'h3F);
        step(1'b0, '0, '0, '0, '0, 1'b0, 4'd15, 6'h3F);

        // Reset mid-cycle while a write is pulsing and three entries wait
        for (int k = 0; k < DEPTH; k++)
            step(1'b1, 4'd7, ADDR_W'(k + 1), 8'hC3, 8'h3C, 1'b1, '0, '0);
        step(1'b0, '0, '0, '0, '0, 1'b0, '0, '0);
        check_value("midrst.pre_count", 32'(bus.count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        for (int k = 0; k < 400; k++) random_step();
        idle(DEPTH + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
